// File: rtl/conv_output_collector.sv
// conv_output_collector: sink side of a convolution layer.
// This block tracks where the current window sits in the frame. It drops sums
// that come from partially filled windows. It requantizes each valid sum to a
// signed 8-bit value and queues it in a first-word-fall-through FIFO. The FIFO
// is read out as a valid/ready stream, and the last output of a frame is marked.
// Optional feature macro: CONV_OUT_RELU_EN. When it is defined, negative results
// are clamped to zero before saturation.
module conv_output_collector #(
  parameter int IMG_WIDTH    = 8,
  parameter int IMG_HEIGHT   = 8,
  parameter int KERNEL_SIZE  = 3,
  parameter int PIPE_LATENCY = 4,
  parameter int SHIFT        = 8,
  parameter int FIFO_DEPTH   = 16
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        pixel_shift,
  input  logic [31:0] conv_sum,
  output logic [7:0]  out_pixel,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        out_last,
  output logic        overflow
);

  localparam int CW = (IMG_WIDTH  > 1) ? $clog2(IMG_WIDTH)  : 1;
  localparam int RW = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;
  localparam int AW = $clog2(FIFO_DEPTH);

  localparam logic [CW-1:0] COL_MAX   = CW'(IMG_WIDTH - 1);
  localparam logic [RW-1:0] ROW_MAX   = RW'(IMG_HEIGHT - 1);
  localparam logic [CW-1:0] COL_START = CW'(KERNEL_SIZE - 1);
  localparam logic [RW-1:0] ROW_START = RW'(KERNEL_SIZE - 1);
  localparam logic [AW:0]   FIFO_FULL_COUNT = (AW+1)'(FIFO_DEPTH);

  // Rounding constant: half of one output LSB, or zero when there is no shift.
  localparam logic [32:0]   RND_U = (33'd1 << SHIFT) >> 1;

  // Window position
  logic [CW-1:0] col_q, col_d;
  logic [RW-1:0] row_q, row_d;
  logic          win_valid, win_last;

  // Tag delay line that lines the window tag up with its sum
  logic [PIPE_LATENCY-1:0] dly_valid_q;
  logic [PIPE_LATENCY-1:0] dly_last_q;

  // Requantization stage
  logic signed [32:0] sum_ext, sum_rnd, sum_shr, sum_clip;
  logic        [7:0]  rq_pix_d;
  logic        [7:0]  rq_pix_q;
  logic               rq_valid_q, rq_last_q;

  // Output FIFO
  logic [8:0]    mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          fifo_full, fifo_empty, do_read, do_write;
  logic          overflow_q, overflow_d;

  // Advance the column/row counters on every pixel shift, wrapping at frame edges
  always_comb begin
    col_d = col_q;
    row_d = row_q;
    if (pixel_shift) begin
      if (col_q == COL_MAX) begin
        col_d = '0;
        if (row_q == ROW_MAX) row_d = '0;
        else                  row_d = row_q + RW'(1);
      end else begin
        col_d = col_q + CW'(1);
      end
    end
  end

  // A window is complete once both the column and the row have filled the kernel
  always_comb begin
    win_valid = pixel_shift && (col_q >= COL_START) && (row_q >= ROW_START);
    win_last  = win_valid && (col_q == COL_MAX) && (row_q == ROW_MAX);
  end

  // Position registers
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      col_q <= '0;
      row_q <= '0;
    end else begin
      col_q <= col_d;
      row_q <= row_d;
    end
  end

  // Delay the {valid,last} tag so it reaches the end at the same time as its conv_sum
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      dly_valid_q <= '0;
      dly_last_q  <= '0;
    end else begin
      dly_valid_q[0] <= win_valid;
      dly_last_q[0]  <= win_last;
      for (int i = 1; i < PIPE_LATENCY; i++) begin
        dly_valid_q[i] <= dly_valid_q[i-1];
        dly_last_q[i]  <= dly_last_q[i-1];
      end
    end
  end

  // Round, arithmetic shift, optional ReLU, then saturate to signed 8 bit
  always_comb begin
    sum_ext = {conv_sum[31], conv_sum};
    sum_rnd = sum_ext + $signed(RND_U);
    sum_shr = sum_rnd >>> SHIFT;
    sum_clip = sum_shr;
`ifdef CONV_OUT_RELU_EN
    if (sum_shr < 33'sd0) sum_clip = 33'sd0;
`else
    sum_clip = sum_shr;
`endif
    if (sum_clip > 33'sd127)       rq_pix_d = 8'h7F;
    else if (sum_clip < -33'sd128) rq_pix_d = 8'h80;
    else                           rq_pix_d = sum_clip[7:0];
  end

  // Register the requantized result together with its delayed tag
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rq_valid_q <= 1'b0;
      rq_last_q  <= 1'b0;
      rq_pix_q   <= '0;
    end else begin
      rq_valid_q <= dly_valid_q[PIPE_LATENCY-1];
      rq_last_q  <= dly_last_q[PIPE_LATENCY-1];
      rq_pix_q   <= rq_pix_d;
    end
  end

  // FIFO control: a read in the same cycle makes room for a write into a full FIFO
  always_comb begin
    fifo_full  = (count_q == FIFO_FULL_COUNT);
    fifo_empty = (count_q == '0);
    do_read    = !fifo_empty && out_ready;
    do_write   = rq_valid_q && (!fifo_full || do_read);
    wr_ptr_d   = do_write ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d   = do_read  ? rd_ptr_q + AW'(1) : rd_ptr_q;
    count_d    = count_q;
    if (do_write && !do_read)      count_d = count_q + (AW+1)'(1);
    else if (!do_write && do_read) count_d = count_q - (AW+1)'(1);
    overflow_d = overflow_q || (rq_valid_q && fifo_full && !do_read);
  end

  // FIFO pointers, occupancy and sticky overflow flag
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  // FIFO storage has no reset, because the occupancy count decides what is visible
  always_ff @(posedge clock) begin
    if (do_write) mem_q[wr_ptr_q] <= {rq_last_q, rq_pix_q};
  end

  // The head entry falls through to the outputs. While the FIFO is empty the outputs are forced to zero
  always_comb begin
    out_valid = !fifo_empty;
    out_pixel = fifo_empty ? 8'h00 : mem_q[rd_ptr_q][7:0];
    out_last  = !fifo_empty && mem_q[rd_ptr_q][8];
    overflow  = overflow_q;
  end

endmodule

// File: tb/tb_conv_output_collector.sv
// Directed testbench for conv_output_collector with the default 8x8, K=3,
// latency-4, shift-8, depth-16 configuration.
module tb_conv_output_collector;

  logic        clock;
  logic        reset;
  logic        pixel_shift;
  logic [31:0] conv_sum;
  logic [7:0]  out_pixel;
  logic        out_valid;
  logic        out_ready;
  logic        out_last;
  logic        overflow;

  int checks   = 0;
  int failures = 0;
  int cycCnt   = 0;
  int firstValidCyc = -1;
  int t18      = 0;
  logic [31:0] sumHist [4];
  logic [8:0]  rxQ [$];

  conv_output_collector dut (
    .clock       (clock),
    .reset       (reset),
    .pixel_shift (pixel_shift),
    .conv_sum    (conv_sum),
    .out_pixel   (out_pixel),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_last    (out_last),
    .overflow    (overflow)
  );

  // 10 ns clock
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Record every accepted output and the first cycle in which out_valid is seen
  always @(negedge clock) begin
    if (!reset && out_valid) begin
      if (firstValidCyc < 0) firstValidCyc = cycCnt;
      if (out_ready) rxQ.push_back({out_last, out_pixel});
    end
  end

  // Compare one observed value against its expected value
  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive one cycle of input. conv_sum follows the pixel it belongs to by four cycles
  task automatic applyStimulus(input logic ps, input logic [31:0] s, input logic rdy);
    @(posedge clock);
    #1;
    pixel_shift = ps;
    conv_sum    = sumHist[3];
    sumHist[3]  = sumHist[2];
    sumHist[2]  = sumHist[1];
    sumHist[1]  = sumHist[0];
    sumHist[0]  = s;
    out_ready   = rdy;
    cycCnt++;
  endtask

  task automatic idle(input int n, input logic rdy);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 32'h0, rdy);
  endtask

  // Assert reset for three cycles. Outputs must stay cleared the whole time
  task automatic doReset();
    @(posedge clock);
    #1;
    reset = 1'b1;
    pixel_shift = 1'b0;
    for (int i = 0; i < 4; i++) sumHist[i] = 32'h0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      checkOutput("reset_out_valid", {31'h0, out_valid}, 32'h0);
    end
    checkOutput("reset_out_last", {31'h0, out_last}, 32'h0);
    checkOutput("reset_overflow", {31'h0, overflow}, 32'h0);
    checkOutput("reset_out_pixel", {24'h0, out_pixel}, 32'h0);
    @(posedge clock);
    #1;
    reset = 1'b0;
    rxQ.delete();
  endtask

  function automatic bit isValidPix(input int p);
    return ((p % 8) >= 2) && ((p / 8) >= 2);
  endfunction

  // mode 0: constant 0x100. mode 1: requant corner cases. mode 2: pixel index << 8
  function automatic logic [31:0] sumFor(input int mode, input int p);
    if (mode == 0) return 32'h100;
    if (mode == 2) return p << 8;
    case (p)
      18:      return 32'h0000_0180;
      19:      return 32'h7FFF_FFFF;
      20:      return 32'h8000_0000;
      21:      return 32'hFFFF_FF00;
      default: return 32'h0;
    endcase
  endfunction

  // Count how many received entries differ from the expected ordered sequence
  function automatic int countErrors(input int mode, input int n);
    int k = 0;
    int errs = 0;
    logic [8:0] expv;
    for (int p = 0; p < 64; p++) begin
      if (isValidPix(p) && k < n) begin
        expv = {(p == 63), (mode == 0) ? 8'd1 : 8'(p)};
        if (k >= rxQ.size() || rxQ[k] !== expv) errs++;
        k++;
      end
    end
    return errs;
  endfunction

  function automatic int countLast();
    int c = 0;
    foreach (rxQ[i]) if (rxQ[i][8]) c++;
    return c;
  endfunction

  function automatic logic [8:0] getRx(input int i);
    if (i < rxQ.size()) return rxQ[i];
    return 9'h1FF;
  endfunction

  initial begin
    reset       = 1'b1;
    pixel_shift = 1'b0;
    conv_sum    = 32'h0;
    out_ready   = 1'b1;
    for (int i = 0; i < 4; i++) sumHist[i] = 32'h0;

    // Reset state, then a full frame with a constant sum, and first-output latency
    doReset();
    firstValidCyc = -1;
    for (int p = 0; p < 64; p++) begin
      applyStimulus(1'b1, sumFor(0, p), 1'b1);
      if (p == 18) t18 = cycCnt;
    end
    idle(12, 1'b1);
    checkOutput("t1_latency", firstValidCyc, t18 + 6);
    checkOutput("t1_count", rxQ.size(), 36);
    checkOutput("t1_value_errs", countErrors(0, 36), 0);
    checkOutput("t1_last_count", countLast(), 1);
    checkOutput("t1_last_on_36th", {23'h0, getRx(35)}, {23'h0, 9'h101});
    checkOutput("t1_overflow", {31'h0, overflow}, 32'h0);

    // Requantization corner cases in the first four windows of the next frame
    rxQ.delete();
    for (int p = 0; p < 64; p++) applyStimulus(1'b1, sumFor(1, p), 1'b1);
    idle(12, 1'b1);
    checkOutput("t3_count", rxQ.size(), 36);
    checkOutput("t3_round_half", {23'h0, getRx(0)}, {23'h0, 9'h002});
    checkOutput("t3_sat_pos", {23'h0, getRx(1)}, {23'h0, 9'h07F});
`ifdef CONV_OUT_RELU_EN
    checkOutput("t3_sat_neg", {23'h0, getRx(2)}, {23'h0, 9'h000});
    checkOutput("t3_minus_one", {23'h0, getRx(3)}, {23'h0, 9'h000});
`else
    checkOutput("t3_sat_neg", {23'h0, getRx(2)}, {23'h0, 9'h080});
    checkOutput("t3_minus_one", {23'h0, getRx(3)}, {23'h0, 9'h0FF});
`endif
    checkOutput("t3_last", {23'h0, getRx(35)}, {23'h0, 9'h100});

    // Back-pressure for a whole frame: 16 results are held, and the 17th sets overflow
    doReset();
    for (int p = 0; p < 64; p++) begin
      applyStimulus(1'b1, sumFor(2, p), 1'b0);
      if (p == 43 || p == 44) begin
        @(negedge clock);
        checkOutput(p == 43 ? "t4_overflow_before" : "t4_overflow_at_17th",
                    {31'h0, overflow}, (p == 43) ? 32'h0 : 32'h1);
      end
    end
    idle(12, 1'b0);
    checkOutput("t4_overflow_sticky", {31'h0, overflow}, 32'h1);
    checkOutput("t4_nothing_accepted", rxQ.size(), 0);
    idle(30, 1'b1);
    checkOutput("t4_drain_count", rxQ.size(), 16);
    checkOutput("t4_drain_order_errs", countErrors(2, 16), 0);
    checkOutput("t4_drained_empty", {31'h0, out_valid}, 32'h0);

    // Full FIFO with a write and a read in the same cycle: no loss and no overflow
    doReset();
    for (int p = 0; p < 64; p++) applyStimulus(1'b1, sumFor(2, p), (p >= 43));
    idle(20, 1'b1);
    checkOutput("t5_count", rxQ.size(), 36);
    checkOutput("t5_order_errs", countErrors(2, 36), 0);
    checkOutput("t5_overflow", {31'h0, overflow}, 32'h0);

    // Reset in the middle of a frame, followed by a clean frame
    for (int p = 0; p < 30; p++) applyStimulus(1'b1, sumFor(2, p), 1'b1);
    doReset();
    for (int p = 0; p < 64; p++) applyStimulus(1'b1, sumFor(2, p), 1'b1);
    idle(12, 1'b1);
    checkOutput("t6_count", rxQ.size(), 36);
    checkOutput("t6_order_errs", countErrors(2, 36), 0);
    checkOutput("t6_last_count", countLast(), 1);
    checkOutput("t6_overflow", {31'h0, overflow}, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
